mem_arbiter: RTL and testbench

- Shares one single-outstanding memory port between NUM_PORTS requesters: instruction fetch, load/store units, or several proc instances.
- Every requester side uses the same pulse-request / pulse-ack handshake as the memory side, so a requester connects to this block exactly as it would connect to memory.
- Requests are latched per port and granted round-robin; one memory transaction is in flight at a time.
- A watchdog retires hung transactions.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
//   e_arb_state : arbiter FSM states (IDLE, WAIT)
//   arb_req_t   : one latched requester transaction
//   rr_index    : rotating scan helper used by the round-robin picker
// ADDR_WIDTH / DATA_WIDTH are also used by the processor and the memory model.
package mem_arb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } e_arb_state;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  we;
  } arb_req_t;

  // Port visited at scan offset 'off' (1..n) after 'last'.
  function automatic int rr_index(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker (combinational).
//   pending    : per-port request-pending mask
//   last_grant : port granted most recently
//   grant      : first pending port after last_grant, wrapping around
//   any_valid  : at least one port pending (grant meaningful only then)
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_valid
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down to the nearest so the nearest
  // pending port after last_grant is the last (winning) assignment.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = IDX_W'(rr_index(int'(last_grant), off, NUM_PORTS));
      if (pending[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between
// NUM_PORTS requesters. Requesters and memory both use pulse-request /
// pulse-ack handshakes, so a requester sees this block as plain memory.
//
// Ports
//   clk, rst       : clock, synchronous active-low reset
//   core_addr      : per-port request address
//   core_wr_data   : per-port write data
//   core_rd_req    : per-port one-cycle read pulse
//   core_wr_req    : per-port one-cycle write pulse (wins over read)
//   core_rd_data   : per-port read data, valid with core_ack
//   core_ack       : per-port one-cycle completion pulse
//   core_busy      : per-port request pending or in flight
//   core_err       : per-port pulse with core_ack when the watchdog retired it
//   mem_addr       : memory address
//   mem_wr_data    : memory write data
//   mem_rd_req     : memory one-cycle read pulse
//   mem_wr_req     : memory one-cycle write pulse
//   mem_rd_data    : memory read data, valid with mem_ack
//   mem_ack        : memory completion pulse
//   mem_busy       : memory cannot accept a request this cycle
//
// TIMEOUT cycles in WAIT without mem_ack force completion with core_err;
// TIMEOUT = 0 disables the watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] core_wr_data,
  input  logic [NUM_PORTS-1:0]                 core_rd_req,
  input  logic [NUM_PORTS-1:0]                 core_wr_req,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] core_rd_data,
  output logic [NUM_PORTS-1:0]                 core_ack,
  output logic [NUM_PORTS-1:0]                 core_busy,
  output logic [NUM_PORTS-1:0]                 core_err,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wr_data,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  input  logic [DATA_WIDTH-1:0]                mem_rd_data,
  input  logic                                 mem_ack,
  input  logic                                 mem_busy
);

  localparam int               IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int               WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit               WD_EN     = (TIMEOUT != 0);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  e_arb_state                 state, state_d;
  logic [NUM_PORTS-1:0]       pending;
  arb_req_t [NUM_PORTS-1:0]   req_q;
  logic [IDX_W-1:0]           last_grant;
  logic [IDX_W-1:0]           cur;
  logic [IDX_W-1:0]           grant;
  logic                       any_valid;
  logic [WD_W-1:0]            wd;
  logic                       issue;
  logic                       ack_done;
  logic                       wd_fire;
  logic                       cmpl;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  // Per-port request latch. A pulse on a port that is already pending is a
  // protocol violation and is dropped. A port may re-request in its ack
  // cycle: pending cleared at the ack edge, so the new pulse is captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      req_q   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pending[p]) begin
          if (cmpl && (cur == IDX_W'(p))) pending[p] <= 1'b0;
        end else if (core_rd_req[p] || core_wr_req[p]) begin
          pending[p]       <= 1'b1;
          req_q[p].addr    <= core_addr[p];
          req_q[p].wr_data <= core_wr_data[p];
          req_q[p].we      <= core_wr_req[p];
        end
      end
    end
  end

  assign core_busy = pending;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (issue) state_d = WAIT;
      WAIT:    if (cmpl)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: control strobes. Acks arriving in IDLE (e.g. after a reset
  // abandoned a transaction) are discarded here.
  always_comb begin
    issue    = 1'b0;
    ack_done = 1'b0;
    wd_fire  = 1'b0;
    unique case (state)
      IDLE: issue = any_valid && !mem_busy;
      WAIT: begin
        ack_done = mem_ack;
        wd_fire  = WD_EN && !mem_ack && (wd == WD_LAST);
      end
      default: ;
    endcase
  end

  assign cmpl = ack_done | wd_fire;

  // Registered datapath: memory-side issue, requester-side completion.
  // Pulsed outputs default low every cycle; everything else holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant   <= LAST_PORT;
      cur          <= '0;
      wd           <= '0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      mem_rd_req   <= 1'b0;
      mem_wr_req   <= 1'b0;
      core_rd_data <= '0;
      core_ack     <= '0;
      core_err     <= '0;
    end else begin
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      core_ack   <= '0;
      core_err   <= '0;

      if (issue) begin
        mem_addr    <= req_q[grant].addr;
        mem_wr_data <= req_q[grant].wr_data;
        mem_wr_req  <= req_q[grant].we;
        mem_rd_req  <= !req_q[grant].we;
        cur         <= grant;
      end

      if ((state == WAIT) && !cmpl) wd <= wd + 1'b1;
      else                          wd <= '0;

      if (cmpl) begin
        core_ack[cur] <= 1'b1;
        core_err[cur] <= wd_fire;
        last_grant    <= cur;
        // A retired transaction returns zero data regardless of direction.
        if (wd_fire)               core_rd_data[cur] <= '0;
        else if (!req_q[cur].we)   core_rd_data[cur] <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NP = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0][31:0]  core_addr, core_wr_data, core_rd_data;
  logic [NP-1:0]        core_rd_req, core_wr_req, core_ack, core_busy, core_err;
  logic [31:0]          mem_addr, mem_wr_data, mem_rd_data;
  logic                 mem_rd_req, mem_wr_req, mem_ack, mem_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_PORTS(NP), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_addr    (core_addr),
    .core_wr_data (core_wr_data),
    .core_rd_req  (core_rd_req),
    .core_wr_req  (core_wr_req),
    .core_rd_data (core_rd_data),
    .core_ack     (core_ack),
    .core_busy    (core_busy),
    .core_err     (core_err),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .mem_rd_data  (mem_rd_data),
    .mem_ack      (mem_ack),
    .mem_busy     (mem_busy)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_exp_t;
  typedef struct { int port; logic [31:0] data; logic err; } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  mem_exp_t me;
  rsp_exp_t re;
  int       checks   = 0;
  int       failures = 0;
  int       mem_lat  = 3;
  bit       mem_noack = 1'b0;
  logic [31:0]   ma;
  logic [NP-1:0] prev_ack = '0;
  logic          prev_mreq = 1'b0;
  bit            re0, re1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  task automatic exp_mem(input logic [31:0] a, input logic we, input logic [31:0] d);
    mem_exp_t e;
    e.addr = a; e.we = we; e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic exp_rsp(input int p, input logic [31:0] d, input logic err);
    rsp_exp_t e;
    e.port = p; e.data = d; e.err = err;
    rsp_q.push_back(e);
  endtask

  task automatic drive_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    core_addr[p]    = a;
    core_wr_data[p] = d;
    if (we) core_wr_req[p] = 1'b1;
    else    core_rd_req[p] = 1'b1;
  endtask

  task automatic clear_reqs();
    core_rd_req = '0;
    core_wr_req = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((mem_q.size() != 0 || rsp_q.size() != 0 || core_busy != '0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (mem_q.size() != 0 || rsp_q.size() != 0 || core_busy != '0) begin
      failures++;
      $display("FAIL %s: drain timeout, issues left %0d responses left %0d busy %b",
               name, mem_q.size(), rsp_q.size(), core_busy);
    end
  endtask

  // Memory model: acks mem_lat negedges after seeing a request; read data is
  // 0xDEADBEEF at 0x40, else {0xA5A5, addr[15:0]}. mem_noack swallows requests.
  initial begin
    mem_ack = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if ((mem_rd_req === 1'b1 || mem_wr_req === 1'b1) && !mem_noack) begin
        ma = mem_addr;
        repeat (mem_lat) @(negedge clk);
        mem_rd_data = (ma == 32'h40) ? 32'hDEADBEEF : {16'hA5A5, ma[15:0]};
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rd_data = '0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a memory request
  // or a requester completion.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_rd_req === 1'b1 || mem_wr_req === 1'b1) begin
        chk1("mem_req_pulse_width", prev_mreq, 1'b0);
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_issue_unexpected: got addr 0x%08h expected no request", mem_addr);
        end else begin
          me = mem_q.pop_front();
          chk("mem_addr", mem_addr, me.addr);
          chk1("mem_wr_req", mem_wr_req, me.we);
          chk1("mem_rd_req", mem_rd_req, !me.we);
          if (me.we) chk("mem_wr_data", mem_wr_data, me.wdata);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (core_err[p] === 1'b1) chk1("err_has_ack", core_ack[p], 1'b1);
        if (core_ack[p] === 1'b1) begin
          chk1("ack_pulse_width", prev_ack[p], 1'b0);
          if (rsp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ack_unexpected: got ack on port %0d expected none", p);
          end else begin
            re = rsp_q.pop_front();
            chk("ack_port", p, re.port);
            chk("core_rd_data", core_rd_data[p], re.data);
            chk1("core_err", core_err[p], re.err);
          end
        end
      end
      prev_ack  = (core_ack === 'x) ? '0 : core_ack;
      prev_mreq = (mem_rd_req === 1'b1) || (mem_wr_req === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0;
    core_addr = '0;
    core_wr_data = '0;
    clear_reqs();
    mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_core_ack", 32'(core_ack), 32'h0);
    chk("rst_core_busy", 32'(core_busy), 32'h0);
    chk("rst_core_err", 32'(core_err), 32'h0);
    chk1("rst_mem_rd_req", mem_rd_req, 1'b0);
    chk1("rst_mem_wr_req", mem_wr_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk("rst_rd_data0", core_rd_data[0], 32'h0);
    chk("rst_rd_data1", core_rd_data[1], 32'h0);
    rst = 1'b1;

    // Simultaneous pair right after reset: last_grant=1, so port 0 first.
    @(negedge clk);
    exp_mem(32'h10, 1'b0, 32'h0);
    exp_mem(32'h20, 1'b1, 32'h5);
    exp_rsp(0, 32'hA5A50010, 1'b0);
    exp_rsp(1, 32'h0, 1'b0);
    drive_req(0, 1'b0, 32'h10, 32'h0);
    drive_req(1, 1'b1, 32'h20, 32'h5);
    @(negedge clk); clear_reqs();
    wait_drain("pair_after_reset", 100);

    // Single read, 3-cycle memory, with latency and busy checks.
    @(negedge clk);
    exp_mem(32'h40, 1'b0, 32'h0);
    exp_rsp(0, 32'hDEADBEEF, 1'b0);
    drive_req(0, 1'b0, 32'h40, 32'h0);
    @(negedge clk); clear_reqs();
    chk1("single_busy_e1", core_busy[0], 1'b1);
    chk1("single_no_req_n0", mem_rd_req, 1'b0);
    @(negedge clk);
    chk1("single_rd_req_n1", mem_rd_req, 1'b1);
    chk("single_mem_addr", mem_addr, 32'h40);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) begin
        chk1("single_busy_hold", core_busy[0], 1'b1);
        chk1("single_no_early_ack", core_ack[0], 1'b0);
      end else begin
        chk1("single_ack_n5", core_ack[0], 1'b1);
        chk1("single_busy_fall", core_busy[0], 1'b0);
      end
    end
    wait_drain("single", 50);

    // Pair again with last_grant=0: port 1 (write) before port 0.
    @(negedge clk);
    exp_mem(32'h20, 1'b1, 32'h5);
    exp_mem(32'h10, 1'b0, 32'h0);
    exp_rsp(1, 32'h0, 1'b0);
    exp_rsp(0, 32'hA5A50010, 1'b0);
    drive_req(0, 1'b0, 32'h10, 32'h0);
    drive_req(1, 1'b1, 32'h20, 32'h5);
    @(negedge clk); clear_reqs();
    wait_drain("pair_rotated", 100);

    // Alternation: each port re-requests in its ack cycle -> 0,1,0,1.
    mem_lat = 2;
    exp_mem(32'h100, 1'b0, 32'h0);
    exp_mem(32'h200, 1'b0, 32'h0);
    exp_mem(32'h104, 1'b0, 32'h0);
    exp_mem(32'h204, 1'b0, 32'h0);
    exp_rsp(0, 32'hA5A50100, 1'b0);
    exp_rsp(1, 32'hA5A50200, 1'b0);
    exp_rsp(0, 32'hA5A50104, 1'b0);
    exp_rsp(1, 32'hA5A50204, 1'b0);
    @(negedge clk); drive_req(0, 1'b0, 32'h100, 32'h0);
    @(negedge clk); clear_reqs(); drive_req(1, 1'b0, 32'h200, 32'h0);
    @(negedge clk); clear_reqs();
    re0 = 1'b0; re1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      clear_reqs();
      if (core_ack[0] && !re0) begin drive_req(0, 1'b0, 32'h104, 32'h0); re0 = 1'b1; end
      if (core_ack[1] && !re1) begin drive_req(1, 1'b0, 32'h204, 32'h0); re1 = 1'b1; end
    end
    clear_reqs();
    wait_drain("alternate", 100);
    mem_lat = 3;

    // mem_busy high for 5 edges: nothing issues until it drops.
    @(negedge clk);
    mem_busy = 1'b1;
    exp_mem(32'h30, 1'b0, 32'h0);
    exp_rsp(0, 32'hA5A50030, 1'b0);
    drive_req(0, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) clear_reqs();
      chk1("busy_no_issue", mem_rd_req | mem_wr_req, 1'b0);
      if (i == 4) mem_busy = 1'b0;
    end
    @(negedge clk);
    chk1("busy_issue_first_free", mem_rd_req, 1'b1);
    wait_drain("mem_busy", 50);

    // Watchdog: memory never acks port 0; retire 8 edges after issue,
    // then port 1 issues and completes normally.
    @(negedge clk);
    mem_noack = 1'b1;
    exp_mem(32'h50, 1'b0, 32'h0);
    exp_mem(32'h60, 1'b0, 32'h0);
    exp_rsp(0, 32'h0, 1'b1);
    exp_rsp(1, 32'hA5A50060, 1'b0);
    drive_req(0, 1'b0, 32'h50, 32'h0);
    @(negedge clk); clear_reqs(); drive_req(1, 1'b0, 32'h60, 32'h0);
    @(negedge clk); clear_reqs();
    chk1("to_issue", mem_rd_req, 1'b1);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      if (i < 9) begin
        chk1("to_no_early_ack", core_ack[0], 1'b0);
      end else begin
        chk1("to_ack", core_ack[0], 1'b1);
        chk1("to_err", core_err[0], 1'b1);
        chk("to_rd_data_zero", core_rd_data[0], 32'h0);
        mem_noack = 1'b0;
      end
    end
    wait_drain("timeout", 100);

    // Reset while in WAIT; the late mem_ack must be discarded.
    mem_lat = 6;
    @(negedge clk);
    exp_mem(32'h70, 1'b0, 32'h0);
    drive_req(0, 1'b0, 32'h70, 32'h0);
    @(negedge clk); clear_reqs();
    @(negedge clk);
    chk1("rw_issue", mem_rd_req, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("rw_core_ack", 32'(core_ack), 32'h0);
    chk("rw_core_busy", 32'(core_busy), 32'h0);
    chk("rw_core_err", 32'(core_err), 32'h0);
    chk1("rw_mem_rd_req", mem_rd_req, 1'b0);
    chk("rw_mem_addr", mem_addr, 32'h0);
    chk("rw_rd_data0", core_rd_data[0], 32'h0);
    chk("rw_rd_data1", core_rd_data[1], 32'h0);
    for (int i = 4; i <= 10; i++) begin
      @(negedge clk);
      chk("rw_late_ack_ignored", 32'(core_ack), 32'h0);
    end
    mem_lat = 3;
    @(negedge clk);
    exp_mem(32'h80, 1'b0, 32'h0);
    exp_rsp(1, 32'hA5A50080, 1'b0);
    drive_req(1, 1'b0, 32'h80, 32'h0);
    @(negedge clk); clear_reqs();
    wait_drain("after_reset", 50);

    repeat (3) @(negedge clk);
    chk("final_mem_q_empty", mem_q.size(), 32'h0);
    chk("final_rsp_q_empty", rsp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
